// File: rtl/rmii_tx_reply.sv
// Builds a 60-byte reply frame on each tx_strobe toggle and serialises it onto RMII, one nibble/clk.
// Define RMII_TX_COUNT_EN to carry a 16-bit frame counter in data bytes 22-23.
module rmii_tx_reply #(
  parameter logic [47:0] DST_MAC     = 48'hffffffffffff,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_strobe,
  input  logic [7:0]  seqnum,
  input  logic [31:0] status,
  output logic [3:0]  rmii_TX,
  output logic [1:0]  rmii_TX_EN,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StFcs  = 3'd3;
  localparam logic [2:0] StIfg  = 3'd4;

  // The IDLE pass-through cycle provides the last idle nibble of the gap, so IFG is one shorter.
  localparam logic [8:0] IfgLast = 9'((IFG_NIBBLES > 1) ? (IFG_NIBBLES - 2) : 0);

  logic [2:0]  state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        strobe_prev_q, pending_q, pending_d;
  logic        req, start, last_fcs;
  logic [7:0]  seq_q;
  logic [31:0] status_q, crc_q, fcs;
  logic [15:0] count_field;
  logic [7:0]  byte_idx, data_byte;
  logic [3:0]  nib, tx_q;
  logic        nib_en, en_q, busy_q, done_q;

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    req       = tx_strobe != strobe_prev_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 9'd1;
    pending_d = pending_q | req;
    start     = 1'b0;
    last_fcs  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req || pending_q) begin
          state_d   = StPre;
          start     = 1'b1;
          // A fresh request arriving while a pending one is consumed queues the next frame.
          pending_d = pending_q & req;
        end
      end
      StPre: if (cnt_q == 9'd15) begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: if (cnt_q == 9'd119) begin
        state_d = StFcs;
        cnt_d   = '0;
      end
      StFcs: if (cnt_q == 9'd7) begin
        last_fcs = 1'b1;
        state_d  = (IFG_NIBBLES > 1) ? StIfg : StIdle;
        cnt_d    = '0;
      end
      StIfg: if (cnt_q == IfgLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_idx = cnt_q[8:1];

  always_comb begin
    data_byte = 8'h00;
    case (byte_idx)
      8'd0:         data_byte = DST_MAC[47:40];
      8'd1:         data_byte = DST_MAC[39:32];
      8'd2:         data_byte = DST_MAC[31:24];
      8'd3:         data_byte = DST_MAC[23:16];
      8'd4:         data_byte = DST_MAC[15:8];
      8'd5:         data_byte = DST_MAC[7:0];
      8'd6:         data_byte = SRC_MAC[47:40];
      8'd7:         data_byte = SRC_MAC[39:32];
      8'd8:         data_byte = SRC_MAC[31:24];
      8'd9:         data_byte = SRC_MAC[23:16];
      8'd10:        data_byte = SRC_MAC[15:8];
      8'd11:        data_byte = SRC_MAC[7:0];
      8'd12, 8'd13: data_byte = 8'h55;
      8'd14:        data_byte = 8'h01;
      8'd16:        data_byte = seq_q;
      8'd18:        data_byte = status_q[7:0];
      8'd19:        data_byte = status_q[15:8];
      8'd20:        data_byte = status_q[23:16];
      8'd21:        data_byte = status_q[31:24];
      8'd22:        data_byte = count_field[7:0];
      8'd23:        data_byte = count_field[15:8];
      default:      data_byte = 8'h00;
    endcase
  end

  assign fcs = ~crc_q;

  always_comb begin
    nib    = 4'h0;
    nib_en = 1'b0;
    case (state_q)
      StPre: begin
        nib_en = 1'b1;
        nib    = (cnt_q == 9'd15) ? 4'hD : 4'h5;
      end
      StData: begin
        nib_en = 1'b1;
        nib    = cnt_q[0] ? data_byte[7:4] : data_byte[3:0];
      end
      StFcs: begin
        nib_en = 1'b1;
        nib    = fcs[{cnt_q[2:0], 2'b00} +: 4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    strobe_prev_q <= tx_strobe;
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      tx_q      <= 4'h0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      tx_q      <= nib;
      en_q      <= nib_en;
      busy_q    <= state_d != StIdle;
      done_q    <= last_fcs;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      seq_q    <= seqnum;
      status_q <= status;
      crc_q    <= 32'hFFFFFFFF;
    end else if (state_q == StData) begin
      crc_q <= crc_nibble(crc_q, nib);
    end
  end

`ifdef RMII_TX_COUNT_EN
  logic [15:0] frame_cnt_q, count_cap_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      count_cap_q <= '0;
    end else begin
      if (last_fcs) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (start)    count_cap_q <= frame_cnt_q;
    end
  end

  assign count_field = count_cap_q;
`else
  assign count_field = 16'h0000;
`endif

  assign rmii_TX    = tx_q;
  assign rmii_TX_EN = {en_q, en_q};
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/rmii_tx_reply.md
Name: rmii_tx_reply

Overview:
Transmit-side companion to the command receiver. Each toggle of the receiver's tx_strobe makes this block build one minimum-size Ethernet reply frame and drive it onto the RMII transmit pins. The frame carries the current sequence number and a 32-bit status word. The RMII pins are serialised two dibits per clk, matching the receive path's nibble-per-clock format. Sits between control and the RMII TX pin registers.

Parameters:
DST_MAC, 48'hffffffffffff, destination address; byte 0 on the wire = DST_MAC[47:40].
SRC_MAC, 48'h020000000001, source address; same byte order.
IFG_NIBBLES, 24, idle clk cycles after each frame (24 = 12 byte times); legal range 1..255.

Ports:
clk  in  1  design clock; one nibble (two RMII dibits) per cycle.
reset_n  in  1  synchronous active-low reset.
tx_strobe  in  1  toggle request from control; each level change requests one frame.
seqnum  in  8  sequence number; captured at frame start.
status  in  32  status word; captured at frame start.
rmii_TX  out  4  TXD nibble; [1:0] is the first dibit on the wire, [3:2] the second.
rmii_TX_EN  out  2  TX_EN per dibit; both bits are always equal.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse on the last FCS nibble.

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE, rmii_TX=0, rmii_TX_EN=0, busy=0, frame_done=0, pending=0.
  - strobe_prev <= tx_strobe, so a level already present at reset never triggers a frame.
- Request detect: req = tx_strobe != strobe_prev. strobe_prev updates every cycle.
- Request in IDLE, or pending set in IDLE:
  - go to PRE next edge; capture seqnum/status; clear pending.
  - First TX_EN-high nibble appears 2 cycles after the edge where req is first seen.
- Request while not IDLE: set pending. Multiple requests while busy coalesce into one pending frame.
- A request in the same cycle pending is consumed re-sets pending.
- States: IDLE -> PRE -> DATA -> FCS -> IFG -> IDLE. A 9-bit nibble counter resets on each state entry.
- PRE: 16 nibbles = 7 bytes 0x55, then 0xD5 (nibbles 5 x15, then D).
- DATA: 60 bytes, low nibble first. Byte map:
  - 0-5: DST_MAC.
  - 6-11: SRC_MAC.
  - 12,13: 0x55.
  - 14: 0x01.
  - 15: 0x00.
  - 16: seqnum.
  - 17: 0x00.
  - 18-21: status, little-endian.
  - 22-23: see optional feature.
  - 24-59: 0x00.
- FCS: CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, updated 4 bits/cycle over DATA nibbles only. Transmit ~crc LSB nibble first, 8 nibbles.
- Frame length: TX_EN high exactly 144 consecutive cycles.
- IFG: TX_EN low, rmii_TX=0 for IFG_NIBBLES cycles. Then IDLE; pending starts the next frame on the following edge.
- rmii_TX is 0 whenever TX_EN is low. All outputs are registered.
- reset_n low mid-frame: the frame is abandoned and TX_EN is 0 from the next cycle. No FCS and no IFG are sent, and pending is lost.

Optional Feature:
Macro RMII_TX_COUNT_EN.
- Defined: a 16-bit frame counter, reset to 0, increments (wrapping) at frame_done. Bytes 22-23 carry the pre-increment count, little-endian, captured at frame start.
- Undefined: bytes 22-23 are 0x00 and the counter does not exist.

Test Plan:
- Single frame, loopback:
  - Stimulus: reset, hold tx_strobe=0, toggle once with seqnum=0x2A, status=0x12345678.
  - Response: TX_EN high 144 cycles starting 2 cycles after the toggle. Decoded bytes 16=0x2A, 18..21=78 56 34 12. Fed through rmii_deframe, Accept pulses once.
- FCS golden: same frame; last 8 nibbles match a software CRC-32 of the 60 data bytes; receiver residue 0xDEBB20E3.
- Busy coalescing: three toggles during frame 1 -> exactly one further frame, starting IFG_NIBBLES+1 cycles after frame_done.
- Reset mid-frame: reset_n low at DATA nibble 50 -> TX_EN=0 next cycle, busy=0, no further frame without a new toggle.
- Reset-level immunity: tx_strobe=1 through reset release, no toggle -> TX_EN stays 0 for 500 cycles.
- Counter (RMII_TX_COUNT_EN): four frames -> bytes 22-23 read 0000, 0100, 0200, 0300. Built without the macro -> bytes 22-23 always 00 00.
